// File: rtl/base_vq_drain.sv
// base_vq_drain: per-tag event accumulator feeding a deduplicating tag queue.
// Events add into a per-tag saturating counter and post their tag on n_*.
// Tags returned on t_* are drained: the count is read, cleared, and emitted
// on o_* through a one-entry output register. Zero-count drains are dropped.
// Optional feature macro: BASE_VQ_DRAIN_SAT_EN adds a per-tag sticky
// saturation flag and the o_sat output port.
module base_vq_drain #(
    parameter int width  = 4,
    parameter int cwidth = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ev_v,
    output logic              ev_r,
    input  logic [width-1:0]  ev_tag,
    input  logic [cwidth-1:0] ev_inc,
    output logic              n_v,
    input  logic              n_r,
    output logic [width-1:0]  n_d,
    input  logic              t_v,
    output logic              t_r,
    input  logic [width-1:0]  t_d,
    output logic              o_v,
    input  logic              o_r,
    output logic [width-1:0]  o_tag,
    output logic [cwidth-1:0] o_cnt
`ifdef BASE_VQ_DRAIN_SAT_EN
    ,
    output logic              o_sat
`endif
);

    localparam int depth = 1 << width;

    logic [cwidth-1:0] cnt [depth];
    logic              ev_fire;
    logic              t_fire;
    logic              same_tag;
    logic [cwidth-1:0] drain_cnt;
    logic [cwidth-1:0] ev_base;
    logic [cwidth:0]   ev_sum;
    logic              ev_clamp;
    logic [cwidth-1:0] ev_val;
    logic              emit;

    // Event path is pure wiring: the event and the notify transfer together.
    assign n_v  = ev_v;
    assign n_d  = ev_tag;
    assign ev_r = n_r;

    // The output register can take a new drain whenever it is empty or emptying.
    assign t_r = ~o_v | o_r;

    assign ev_fire   = ev_v & n_r;
    assign t_fire    = t_v & t_r;
    assign same_tag  = t_fire && (t_d == ev_tag);
    assign drain_cnt = cnt[t_d];

    // Compute the saturating update for the event's counter; a same-cycle
    // drain of that tag means the increment lands on a freshly cleared count.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' and assigns every output
        // at the top so no path leaves a value unassigned (which would infer a latch).
        ev_base  = same_tag ? '0 : cnt[ev_tag];
        ev_sum   = {1'b0, ev_base} + {1'b0, ev_inc};
        ev_clamp = ev_sum[cwidth];
        ev_val   = ev_clamp ? '1 : ev_sum[cwidth-1:0];
    end

`ifdef BASE_VQ_DRAIN_SAT_EN
    logic [depth-1:0] sticky;
    logic             ev_sticky_base;

    assign ev_sticky_base = same_tag ? 1'b0 : sticky[ev_tag];
    assign emit           = (drain_cnt != '0) | sticky[t_d];

    // Sticky flag: set when an event clamps, cleared when its tag is drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky <= '0;
        end else begin
            for (int i = 0; i < depth; i++) begin
                if (ev_fire && ev_tag == width'(i)) begin
                    sticky[i] <= ev_sticky_base | ev_clamp;
                end else if (t_fire && t_d == width'(i)) begin
                    sticky[i] <= 1'b0;
                end
            end
        end
    end
`else
    assign emit = (drain_cnt != '0);
`endif

    // Counter array: event update takes priority since it already folds in a
    // same-tag drain; otherwise a drain clears its counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the counters must read zero after reset, so this storage is
            // reset explicitly as registers rather than left as an uninitialised RAM.
            for (int i = 0; i < depth; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so every register
            // samples the pre-edge values regardless of statement order.
            for (int i = 0; i < depth; i++) begin
                if (ev_fire && ev_tag == width'(i)) begin
                    cnt[i] <= ev_val;
                end else if (t_fire && t_d == width'(i)) begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // One-entry output register: load on a drain worth emitting, drop when consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_v   <= 1'b0;
            o_tag <= '0;
            o_cnt <= '0;
`ifdef BASE_VQ_DRAIN_SAT_EN
            o_sat <= 1'b0;
`endif
        end else if (t_fire) begin
            o_v <= emit;
            if (emit) begin
                o_tag <= t_d;
                o_cnt <= drain_cnt;
`ifdef BASE_VQ_DRAIN_SAT_EN
                o_sat <= sticky[t_d];
`endif
            end
        end else if (o_r) begin
            o_v <= 1'b0;
        end
    end

endmodule
